// File: rtl/dbu_run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dbu_run_ctrl_pkg
// Shared definitions for the debug-unit run controller: default widths of the
// inspection address and the retired-instruction counter, and the run-state
// encoding used by the controller FSM.
// BPHOLD is only reachable when DBU_BREAKPOINT_EN is defined; the encoding is
// kept here unconditionally so every build agrees on the state values.
// -----------------------------------------------------------------------------
package dbu_run_ctrl_pkg;

    localparam int DBU_ADDR_W = 8;
    localparam int DBU_CNT_W  = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_STEP   = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_BPHOLD = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_RUN    = ST_RUN,
        S_STEP   = ST_STEP,
        S_DRAIN  = ST_DRAIN,
        S_BPHOLD = ST_BPHOLD
    } dbu_state_e;

    // The CPU is allowed to advance only in these states.
    function automatic logic state_runs_cpu(input dbu_state_e s);
        return (s == S_RUN) || (s == S_STEP) || (s == S_DRAIN);
    endfunction

endpackage

// File: rtl/dbu_run_ctrl_edge.sv
// -----------------------------------------------------------------------------
// signal_edge
// Rising-edge detector for a raw (asynchronous) board button. Two flops bring
// the button into the clk domain; the rise is then registered so sig_e is high
// for exactly one cycle, starting two clocks after the raw rise. A held button
// produces a single event.
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous reset, active high
//   sig   in  raw button level
//   sig_e out one-cycle rising-edge event
// -----------------------------------------------------------------------------
module signal_edge (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic sig_e
);

    logic [1:0] sync_reg;
    logic       sig_e_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg  <= 2'b00;
            sig_e_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], sig};
            sig_e_reg <= sync_reg[0] & ~sync_reg[1];
        end
    end

    assign sig_e = sig_e_reg;

endmodule

// File: rtl/dbu_run_ctrl.sv
// -----------------------------------------------------------------------------
// dbu_run_ctrl
// Run controller of the debug unit for the multicycle MIPS CPU. Gates CPU
// progress (continuous run, single-instruction step, drain-to-fetch-boundary
// stop), holds the memory/register-file inspection address and counts
// retired instructions.
//
// Optional feature macro: DBU_BREAKPOINT_EN
//   When defined, adds bp_addr/bp_hit and the BPHOLD state: while running, an
//   instruction boundary whose next PC equals bp_addr freezes the CPU before
//   that instruction starts.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active high
//   succ        in   level switch, 1 = continuous run requested
//   step        in   raw button, execute one instruction
//   inc / dec   in   raw buttons, view_addr +1 / -1
//   instr_done  in   1-cycle pulse when the CPU FSM returns to fetch
//   pc          in   PC of the next instruction (valid with instr_done)
//   bp_addr     in   breakpoint address (DBU_BREAKPOINT_EN only)
//   cpu_run     out  CPU enable
//   halted      out  1 while IDLE
//   view_addr   out  inspection address
//   instr_cnt   out  instructions retired since reset (wraps)
//   bp_hit      out  sticky breakpoint flag (DBU_BREAKPOINT_EN only)
// -----------------------------------------------------------------------------
module dbu_run_ctrl
    import dbu_run_ctrl_pkg::*;
#(
    parameter int ADDR_W = DBU_ADDR_W,
    parameter int CNT_W  = DBU_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              succ,
    input  logic              step,
    input  logic              inc,
    input  logic              dec,
    input  logic              instr_done,
    input  logic [31:0]       pc,
`ifdef DBU_BREAKPOINT_EN
    input  logic [31:0]       bp_addr,
    output logic              bp_hit,
`endif
    output logic              cpu_run,
    output logic              halted,
    output logic [ADDR_W-1:0] view_addr,
    output logic [CNT_W-1:0]  instr_cnt
);

    // Button edge events: bit 0 = step, 1 = inc, 2 = dec.
    logic [2:0] btn_raw;
    logic [2:0] btn_e;
    logic       step_e;
    logic       inc_e;
    logic       dec_e;

    assign btn_raw = {dec, inc, step};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn_edge
            signal_edge u_edge (
                .clk   (clk),
                .rst   (rst),
                .sig   (btn_raw[gi]),
                .sig_e (btn_e[gi])
            );
        end
    endgenerate

    assign step_e = btn_e[0];
    assign inc_e  = btn_e[1];
    assign dec_e  = btn_e[2];

    dbu_state_e        state_reg;
    dbu_state_e        state_next;
    logic [ADDR_W-1:0] view_addr_reg;
    logic [CNT_W-1:0]  instr_cnt_reg;
    logic              bp_stop;

`ifdef DBU_BREAKPOINT_EN
    assign bp_stop = instr_done && (pc == bp_addr);
`else
    assign bp_stop = 1'b0;
    // pc only matters for breakpoint matching.
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

    // ------------------------------------------------------------------ FSM
    // Stopping is only ever decided on instr_done, so the CPU always ends up
    // frozen at its fetch boundary; DRAIN waits for that boundary.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (succ)        state_next = S_RUN;
                else if (step_e) state_next = S_STEP;
            end
            S_RUN: begin
                if (bp_stop)                  state_next = S_BPHOLD;
                else if (!succ && instr_done) state_next = S_IDLE;
                else if (!succ)               state_next = S_DRAIN;
            end
            S_STEP: begin
                if (instr_done) state_next = S_IDLE;
            end
            S_DRAIN: begin
                if (instr_done) state_next = S_IDLE;
            end
            S_BPHOLD: begin
                if (!succ) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    // Outputs decode straight from the state register so they follow the
    // asynchronous reset immediately.
    assign cpu_run = state_runs_cpu(state_reg);
    assign halted  = (state_reg == S_IDLE);

    // ------------------------------------------------------- counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt_reg <= '0;
        end else if (instr_done && cpu_run) begin
            instr_cnt_reg <= instr_cnt_reg + CNT_W'(1);
        end
    end

    // Simultaneous inc/dec cancel out; wrap is natural modulo arithmetic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            view_addr_reg <= '0;
        end else if (inc_e && !dec_e) begin
            view_addr_reg <= view_addr_reg + ADDR_W'(1);
        end else if (dec_e && !inc_e) begin
            view_addr_reg <= view_addr_reg - ADDR_W'(1);
        end
    end

    assign view_addr = view_addr_reg;
    assign instr_cnt = instr_cnt_reg;

`ifdef DBU_BREAKPOINT_EN
    // Sticky until the operator starts the CPU again from IDLE.
    logic bp_hit_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_hit_reg <= 1'b0;
        end else if (state_reg == S_RUN && state_next == S_BPHOLD) begin
            bp_hit_reg <= 1'b1;
        end else if (state_reg == S_IDLE && state_next != S_IDLE) begin
            bp_hit_reg <= 1'b0;
        end
    end

    assign bp_hit = bp_hit_reg;
`endif

endmodule
